// File: rtl/sync_fifo_v2_if.sv
// Bundle of the sync_fifo_v2 request, data and status signals.
// The producer/consumer side drives through the master modport, and the FIFO uses the slave modport.
interface sync_fifo_v2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    // Handshake: a write takes effect at the edge where wr_en=1 and the FIFO is not full.
    // A write while full also takes effect if a read is accepted at the same edge.
    // A read takes effect at the edge where rd_en=1 and empty=0.
    // valid marks the cycles in which dout carries a popped word (standard mode) or the head word (FWFT mode).
    // There is no backpressure beyond full/empty.
    // A rejected request sets the sticky overflow or underflow flag.
    logic                  clr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wr_en, rd_en, data,
        input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, rd_en, data,
        output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_v2.sv
// Synchronous byte FIFO for the UART datapath: it reports occupancy, has programmable almost-full/almost-empty thresholds,
// sticky error flags and a synchronous flush, and offers a selectable registered or first-word-fall-through read.
module sync_fifo_v2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input logic           clk,
    input logic           rst,
    sync_fifo_v2_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_w;
    logic                  empty_w;
    logic                  rd_ok;
    logic                  wr_ok;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);
    assign rd_ok   = bus.rd_en & ~empty_w;
    // A write at full is accepted when a pop frees the slot at the same edge.
    assign wr_ok   = bus.wr_en & (~full_w | rd_ok);

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // Array is not reset. Writes are suppressed during reset and flush so no stale word is stored.
    always_ff @(posedge clk) begin
        if (wr_ok && rst && !bus.clr) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.wr_en && !wr_ok) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && !rd_ok) begin
                underflow_q <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.dout  = mem[rd_ptr];
        assign bus.valid = ~empty_w;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;

        // dout holds its last popped word through idle cycles and flush.
        always_ff @(posedge clk) begin
            if (!rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else if (bus.clr) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_ok;
                if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end
        end

        assign bus.dout  = dout_q;
        assign bus.valid = valid_q;
    end
endmodule

// File: doc/sync_fifo_v2.md
# sync_fifo_v2

Parametrised synchronous FIFO for the UART datapath, the second generation of the team's `fifo`. It buffers bytes between the baud-rate TX/RX engines and the host side. Over the first generation it adds:
- occupancy count and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags and a synchronous flush;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH (16)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_THRESH, 12, almost_full asserts when count >= this value
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value
- Legal parameters: 1 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- clr  in  1  synchronous flush, active high
- wr_en  in  1  write request
- rd_en  in  1  read request (pop)
- data  in  DATA_WIDTH  write data
- dout  out  DATA_WIDTH  read data
- valid  out  1  dout carries a word (see Operation)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  words stored, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: DEPTH x DATA_WIDTH array, write and read pointers of ADDR_WIDTH bits. Pointers wrap naturally from DEPTH-1 to 0. Array contents are not reset.
- Read accept: `rd_ok = rd_en & ~empty`.
- Write accept: `wr_ok = wr_en & (~full | rd_ok)`. A write while full is accepted only if a read is accepted in the same cycle.
- Count update:
  - +1 on wr_ok only;
  - -1 on rd_ok only;
  - unchanged when both or neither.
- full, empty, almost_full and almost_empty are decoded from the registered count. They change on the same edge as count.
- Rejected requests:
  - wr_en while full with no rd_ok sets overflow; the data is discarded.
  - rd_en while empty sets underflow; this holds even if a write is accepted in the same cycle.
  - Both flags stay set until clr or reset.
- Standard mode (FWFT=0):
  - On rd_ok, dout loads the head word at the next edge and valid is 1 for that one cycle.
  - Otherwise valid is 0 and dout holds its last value.
- FWFT mode (FWFT=1):
  - dout always shows the head word: `mem[rd_ptr]`, combinational from the array.
  - valid = ~empty.
  - rd_en acknowledges the displayed word and advances to the next one.
- Priority: rst, then clr, then normal operation.
- clr:
  - pointers and count go to 0, overflow and underflow clear, valid goes to 0;
  - dout is held in standard mode;
  - wr_en and rd_en in the clr cycle are ignored and set no error flags.

## Timing
- Reset values: count 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, valid 0, dout 0 in standard mode. Pointers are 0.
- Reset mid-operation: all outputs take their reset values at the edge where rst is sampled 0. Stored data is lost logically.
- Write to visibility:
  - A word written at edge N is counted at N; empty deasserts after N.
  - FWFT: dout/valid show the word in the cycle after edge N.
  - Standard: rd_en asserted after N yields dout/valid one edge later.
- Read latency, standard mode: rd_en sampled at edge N gives dout/valid at edge N (registered), visible in cycle N+1.
- Throughput: one write and one read per cycle, sustained, including at full (count stays DEPTH) and at count 1.
- Flag latency: overflow and underflow assert at the edge that samples the rejected request.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with wr_en=1, data=8'hA1 → after release, count=0, empty=1, almost_empty=1, all other flags 0; no word stored.
- **Fill, standard mode:** write 8'h00..8'h0F over 16 cycles → almost_full asserts when count reaches 12; full=1 at count=16.
  - A 17th write of 8'hFF → overflow=1, count stays 16.
  - Reading 16 words → dout 8'h00..8'h0F in order, each one cycle after rd_en; 8'hFF never appears.
- **Simultaneous access:**
  - At full, wr_en=rd_en=1 with 8'h53 → count stays 16, no overflow; 8'h53 is read last after the remaining 15.
  - At empty, wr_en=rd_en=1 → underflow=1, count becomes 1.
- **FWFT=1:** write 8'hA1, 8'hFF, 8'h00 → dout=8'hA1 with valid=1 the cycle after the first write, with no rd_en. Each rd_en advances to 8'hFF, then 8'h00; valid=0 after the third pop.
- **Pointer wrap:** 40 cycles of interleaved writes/reads with count oscillating between 3 and 5 → data order preserved across pointer wraps; almost_empty tracks count <= 2 on every edge.
- **Flush mid-stream:** with 7 words stored and overflow=1, assert clr together with wr_en and rd_en → next cycle count=0, empty=1, overflow=0, underflow=0; the clr-cycle write is not stored.
